bvadd_inv_witness_checker: RTL and testbench

Sequential checker that validates witnesses produced by the 4-bit bvadd-inverse Skolem function. It receives tuples (s, t, x) over a valid/ready handshake and evaluates the forward equation x + s mod 2^WIDTH bit-serially, LSB first. It compares the result against t and returns pass/fail over a second handshake. Running pass/fail counts are kept. It sits downstream of the combinational Skolem block in the regression harness and closes the loop on it.

---
 rtl/bvadd_inv_witness_checker.sv | 179 +++++++++++++++++
 tb/tb_bvadd_inv_witness_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bvadd_inv_witness_checker.sv
// bvadd_inv_witness_checker
//
// Checks witnesses produced by the bvadd-inverse Skolem function. A tuple
// (s, t, x) is accepted over a valid/ready handshake. The checker then forms
// x + s mod 2^WIDTH bit-serially, LSB first, over exactly WIDTH cycles and
// compares the result with t. It returns pass/fail and the computed sum over
// a second valid/ready handshake, and keeps saturating pass/fail counters.
//
// Optional feature macro: BVADD_CHK_CAPTURE_EN. When it is defined, the block
// captures the first failing tuple seen since reset or cnt_clr on the ff_*
// ports.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     tuple handshake (in_ready high only in IDLE)
//   in_s, in_t, in_x      addend, expected sum, candidate witness
//   res_valid/res_ready   result handshake (res_valid high only in RESP)
//   res_pass, res_sum     result flag and computed sum, held through RESP
//   busy                  high while in ADD or RESP
//   cnt_clr               synchronous clear of counters (and capture)
//   pass_cnt, fail_cnt    saturating tuple counters
//   ff_vld, ff_s/t/x      first-fail capture (BVADD_CHK_CAPTURE_EN only)
module bvadd_inv_witness_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_x,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_pass,
    output logic [WIDTH-1:0] res_sum,
    output logic             busy,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef BVADD_CHK_CAPTURE_EN
    ,
    output logic             ff_vld,
    output logic [WIDTH-1:0] ff_s,
    output logic [WIDTH-1:0] ff_t,
    output logic [WIDTH-1:0] ff_x
`endif
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] s_q, t_q, x_q;
    logic [WIDTH-1:0] sum_q, sum_nxt;
    logic [IW-1:0]    idx_q;
    logic             carry_q, carry_nxt, sum_bit;
    logic             accept, add_done, tuple_pass;

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        add_done  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid) state_nxt = ADD;
            end
            ADD: begin
                add_done = (idx_q == LAST_IDX);
                if (add_done) state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- bit-serial adder ----------------
    // The final sum includes the bit being formed in the last ADD cycle. It
    // is therefore built combinationally so it can be registered into
    // res_sum on the same edge that leaves ADD.
    always_comb begin
        sum_bit    = s_q[idx_q] ^ x_q[idx_q] ^ carry_q;
        carry_nxt  = (s_q[idx_q] & x_q[idx_q]) | (s_q[idx_q] & carry_q) |
                     (x_q[idx_q] & carry_q);
        sum_nxt    = sum_q;
        sum_nxt[idx_q] = sum_bit;
        tuple_pass = (sum_nxt == t_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q      <= '0;
            t_q      <= '0;
            x_q      <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            res_sum  <= '0;
            res_pass <= 1'b0;
        end else begin
            if (accept) begin
                s_q     <= in_s;
                t_q     <= in_t;
                x_q     <= in_x;
                sum_q   <= '0;
                idx_q   <= '0;
                carry_q <= 1'b0;
            end else if (state == ADD) begin
                sum_q   <= sum_nxt;
                carry_q <= carry_nxt;
                idx_q   <= idx_q + IW'(1);
            end
            if (add_done) begin
                res_sum  <= sum_nxt;
                res_pass <= tuple_pass;
            end
        end
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (cnt_clr) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (add_done) begin
            if (tuple_pass) begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
            end
        end
    end

`ifdef BVADD_CHK_CAPTURE_EN
    // ---------------- first-fail capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vld <= 1'b0;
            ff_s   <= '0;
            ff_t   <= '0;
            ff_x   <= '0;
        end else if (cnt_clr) begin
            ff_vld <= 1'b0;
            ff_s   <= '0;
            ff_t   <= '0;
            ff_x   <= '0;
        end else if (add_done && !tuple_pass && !ff_vld) begin
            ff_vld <= 1'b1;
            ff_s   <= s_q;
            ff_t   <= t_q;
            ff_x   <= x_q;
        end
    end
`endif

endmodule

// File: tb/tb_bvadd_inv_witness_checker.sv
module tb_bvadd_inv_witness_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, res_ready, cnt_clr;
    logic [W-1:0] in_s, in_t, in_x;
    logic         in_ready, res_valid, res_pass, busy;
    logic [W-1:0] res_sum;
    logic [15:0]  pass_cnt, fail_cnt;
    logic         in_ready2, res_valid2, res_pass2, busy2;
    logic [W-1:0] res_sum2;
    logic [1:0]   pass_cnt2, fail_cnt2;
`ifdef BVADD_CHK_CAPTURE_EN
    logic         ff_vld, ff_vld2;
    logic [W-1:0] ff_s, ff_t, ff_x, ff_s2, ff_t2, ff_x2;
`endif

    always #5 clk = ~clk;

    bvadd_inv_witness_checker #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_t(in_t), .in_x(in_x), .res_valid(res_valid),
        .res_ready(res_ready), .res_pass(res_pass), .res_sum(res_sum),
        .busy(busy), .cnt_clr(cnt_clr), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
`ifdef BVADD_CHK_CAPTURE_EN
        , .ff_vld(ff_vld), .ff_s(ff_s), .ff_t(ff_t), .ff_x(ff_x)
`endif
    );

    // Narrow-counter instance sharing all inputs, used for saturation.
    bvadd_inv_witness_checker #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_s(in_s), .in_t(in_t), .in_x(in_x), .res_valid(res_valid2),
        .res_ready(res_ready), .res_pass(res_pass2), .res_sum(res_sum2),
        .busy(busy2), .cnt_clr(cnt_clr), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
`ifdef BVADD_CHK_CAPTURE_EN
        , .ff_vld(ff_vld2), .ff_s(ff_s2), .ff_t(ff_t2), .ff_x(ff_x2)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_pass, m_fail, m_pass2, m_fail2;
    bit m_ff_vld;
    int m_ff_s, m_ff_t, m_ff_x;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic model_clear();
        m_pass = 0; m_fail = 0; m_pass2 = 0; m_fail2 = 0;
        m_ff_vld = 0; m_ff_s = 0; m_ff_t = 0; m_ff_x = 0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_pass_cnt"}, int'(pass_cnt), m_pass);
        chk({tag, "_fail_cnt"}, int'(fail_cnt), m_fail);
        chk({tag, "_pass_cnt2"}, int'(pass_cnt2), m_pass2);
        chk({tag, "_fail_cnt2"}, int'(fail_cnt2), m_fail2);
`ifdef BVADD_CHK_CAPTURE_EN
        chk({tag, "_ff_vld"}, int'(ff_vld), int'(m_ff_vld));
        chk({tag, "_ff_s"}, int'(ff_s), m_ff_s);
        chk({tag, "_ff_t"}, int'(ff_t), m_ff_t);
        chk({tag, "_ff_x"}, int'(ff_x), m_ff_x);
`endif
    endtask

    // Called one time unit after a rising edge with the DUT in IDLE.
    task automatic run_tuple(input int s, input int t, input int x,
                             input int stall, input bit clr_late);
        int lat;
        int exp_sum;
        bit exp_pass;
        in_s = W'(s); in_t = W'(t); in_x = W'(x);
        in_valid = 1'b1;
        res_ready = 1'b0;
        chk("in_ready_idle", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // operands must be sampled only at acceptance
        in_s = W'($urandom); in_t = W'($urandom); in_x = W'($urandom);
        lat = 0;
        while (!res_valid && lat < 12) begin
            if (clr_late && lat == W - 1) cnt_clr = 1'b1;
            @(posedge clk); #1;
            cnt_clr = 1'b0;
            lat++;
        end
        chk("latency", lat, W);

        exp_sum  = (s + x) % (1 << W);
        exp_pass = (exp_sum == t);
        if (clr_late) begin
            model_clear();
        end else if (exp_pass) begin
            m_pass  = sat_inc(m_pass, 65535);
            m_pass2 = sat_inc(m_pass2, 3);
        end else begin
            m_fail  = sat_inc(m_fail, 65535);
            m_fail2 = sat_inc(m_fail2, 3);
            if (!m_ff_vld) begin
                m_ff_vld = 1; m_ff_s = s; m_ff_t = t; m_ff_x = x;
            end
        end

        chk("res_sum", int'(res_sum), exp_sum);
        chk("res_pass", int'(res_pass), int'(exp_pass));
        chk("busy_resp", int'(busy), 1);
        chk_counts("resp");

        for (int k = 0; k < stall; k++) begin
            in_valid = 1'(($urandom % 2));
            in_s = W'($urandom); in_t = W'($urandom); in_x = W'($urandom);
            @(posedge clk); #1;
            chk("stall_res_valid", int'(res_valid), 1);
            chk("stall_res_sum", int'(res_sum), exp_sum);
            chk("stall_res_pass", int'(res_pass), int'(exp_pass));
            chk("stall_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("post_in_ready", int'(in_ready), 1);
        chk("post_res_valid", int'(res_valid), 0);
        chk("post_busy", int'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0; cnt_clr = 1'b0;
        in_s = '0; in_t = '0; in_x = '0;
        model_clear();
        #3;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_pass", int'(res_pass), 0);
        chk("rst_res_sum", int'(res_sum), 0);
        chk("rst_busy", int'(busy), 0);
        chk_counts("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // res_ready outside RESP has no effect
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("idle_rdy_in_ready", int'(in_ready), 1);
        chk("idle_rdy_res_valid", int'(res_valid), 0);

        run_tuple(3, 8, 5, 0, 0);
        run_tuple(15, 0, 1, 0, 0);
        run_tuple(15, 14, 15, 0, 0);
        run_tuple(2, 5, 2, 0, 0);
        run_tuple(1, 0, 1, 0, 0);
        run_tuple(6, 9, 3, 3, 0);

        // reset during ADD
        in_s = 4'd7; in_t = 4'd1; in_x = 4'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("mid_add_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_res_pass", int'(res_pass), 0);
        chk("arst_res_sum", int'(res_sum), 0);
        chk("arst_busy", int'(busy), 0);
        chk_counts("arst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_in_ready", int'(in_ready), 1);
        run_tuple(1, 2, 1, 0, 0);

        // randomized tuples, about half constructed to pass
        for (int i = 0; i < 40; i++) begin
            int s, x, t;
            s = int'($urandom % 16);
            x = int'($urandom % 16);
            t = ($urandom % 2) ? (s + x) % 16 : int'($urandom % 16);
            run_tuple(s, t, x, int'($urandom % 4), 0);
        end

        // counter clear, saturation, and clear winning over an increment
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        model_clear();
        chk_counts("clr");
        for (int i = 0; i < 5; i++) run_tuple(i, (i + 4) % 16, 4, 0, 0);
        chk("sat_pass_cnt2", int'(pass_cnt2), 3);
        run_tuple(2, 5, 3, 0, 1);
        chk("clr_win_pass_cnt", int'(pass_cnt), 0);
        chk("clr_win_pass_cnt2", int'(pass_cnt2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
